load_store_unit: RTL

- Sits between the RISC-V core's execute stage and the word-wide data memory (14-bit word index, address bits [15:2]).
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory accesses.
- Performs read-merge-write for sub-word stores and splits misaligned accesses into two word accesses.
- Stalls the core through a ready/done handshake.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_lane_align.sv | 26 ++
 rtl/load_store_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and access-size helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} lsu_state_t;
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: places store bytes into word 0 or word 1 of an access and merges with the old word
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        sel,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [3:0]  mask
);
  logic [63:0] sdata;
  logic [7:0]  smask;
  logic [31:0] word;
  assign sdata = {32'd0, wdata} << {off, 3'b000};
  assign smask = {4'd0, (4'd1 << size) - 4'd1} << off;
  assign mask  = sel ? smask[7:4] : smask[3:0];
  assign word  = sel ? sdata[63:32] : sdata[31:0];
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lane
      assign merged[8*i +: 8] = mask[i] ? word[8*i +: 8] : old_word[8*i +: 8];
    end
  endgenerate
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word loads and stores into one or two whole-word memory accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  Mem_Write_o,
  output logic                  Mem_Read_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);
  lsu_state_t  state, state_nx;
  logic        we_r, err_r, span, acc, sel;
  logic [2:0]  f3_r, size;
  logic [1:0]  off;
  logic [31:0] addr_r, wdata_r, ld_lo, base, merged, ld_sh, ld_val;
  logic [3:0]  mask;
  logic [63:0] ld_cat;
  assign off  = addr_r[1:0];
  assign size = size_of(f3_r);
  assign span = ({1'b0, off} + size) > 3'd4;
  assign acc  = state == S_ACC0 || state == S_ACC1;
  assign sel  = state == S_ACC1;
  assign base = {addr_r[31:2], 2'b00} + (sel ? 32'd4 : 32'd0);
  lsu_lane_align u_align (
    .off     (off),
    .size    (size),
    .sel     (sel),
    .wdata   (wdata_r),
    .old_word(Read_Data_i),
    .merged  (merged),
    .mask    (mask)
  );
  // strobes come straight from state so an async reset kills a write mid-cycle
  assign ready_o      = state == S_IDLE;
  assign done_o       = state == S_DONE;
  assign err_o        = done_o && err_r;
  assign Mem_Read_o   = acc;
  assign Mem_Write_o  = acc && we_r && |mask;
  assign Address_o    = acc ? base : '0;
  assign Write_Data_o = Mem_Write_o ? merged : '0;
  // the word arriving this cycle is folded in so rdata_o is ready as DONE is entered
  assign ld_cat = sel ? {Read_Data_i, ld_lo} : {32'd0, Read_Data_i};
  assign ld_sh  = 32'(ld_cat >> {off, 3'b000});
  always_comb begin
    ld_val = f3_r == F3_B  ? {{24{ld_sh[7]}}, ld_sh[7:0]} :
             f3_r == F3_H  ? {{16{ld_sh[15]}}, ld_sh[15:0]} :
             f3_r == F3_BU ? {24'd0, ld_sh[7:0]} :
             f3_r == F3_HU ? {16'd0, ld_sh[15:0]} : ld_sh;
    state_nx = state == S_IDLE ? (req_i ? (is_legal(we_i, funct3_i) ? S_ACC0 : S_DONE) : S_IDLE) :
               state == S_ACC0 ? (span ? S_ACC1 : S_DONE) :
               state == S_ACC1 ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      f3_r    <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      ld_lo   <= '0;
      rdata_o <= '0;
    end else begin
      state <= state_nx;
      if (ready_o && req_i) begin
        we_r    <= we_i;
        f3_r    <= funct3_i;
        addr_r  <= addr_i;
        wdata_r <= wdata_i;
        err_r   <= !is_legal(we_i, funct3_i);
      end
      if (state == S_ACC0) ld_lo <= Read_Data_i;
      if (acc && state_nx == S_DONE && !we_r) rdata_o <= ld_val;
    end
  end
endmodule
